// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner
//   Front end for the vending machine controller. Every raw sensor and button
//   line is synchronised and debounced. Buttons become one-cycle pulses.
//   Coins are queued per denomination and replayed one at a time through a
//   small emit FSM, so the controller never sees two coins in the same cycle.
//
//   Optional feature: define JAM_DETECT_EN to enable per-coin hold counters.
//   These set a sticky JAM flag and block further coin acceptance.
//
// Ports
//   CLOCK                 in   system clock, rising-edge active
//   nRESET                in   synchronous active-low reset
//   RAW_COIN_1/5/10       in   asynchronous coin sensor lines
//   RAW_START/OK/SELECT   in   asynchronous push-button lines
//   COIN_1/5/10           out  one-cycle pulse per accepted coin, never overlapping
//   START/OK/SELECT       out  one-cycle pulse per debounced press
//   COIN_OVF              out  one-cycle pulse when a coin is dropped on a full queue
//   JAM                   out  sticky jam flag (0 unless JAM_DETECT_EN)
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PEND_MAX        = 3,
  parameter int GAP_CYCLES      = 1,
  parameter int JAM_CYCLES      = 64
) (
  input  logic CLOCK,
  input  logic nRESET,
  input  logic RAW_COIN_1,
  input  logic RAW_COIN_5,
  input  logic RAW_COIN_10,
  input  logic RAW_START,
  input  logic RAW_OK,
  input  logic RAW_SELECT,
  output logic COIN_1,
  output logic COIN_5,
  output logic COIN_10,
  output logic START,
  output logic OK,
  output logic SELECT,
  output logic COIN_OVF,
  output logic JAM
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2 || GAP_CYCLES < 1 || PEND_MAX < 1 || PEND_MAX > 3 ||
      JAM_CYCLES < 1) begin : g_bad_params
    $error("coin_input_conditioner: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  // Channel order: [0]=coin1 [1]=coin5 [2]=coin10 [3]=start [4]=ok [5]=select
  logic [5:0]       raw;
  logic [5:0]       sync_p0, sync_p1;
  logic [5:0]       db, db_d;
  logic [5:0]       rise;
  logic [CNT_W-1:0] cnt [6];

  logic [1:0]       pend [3];
  logic [2:0]       acc, deq, drop, pick, sel;
  logic [2:0]       btn;
  logic             ovf;
  logic             jam;
  logic [GAP_W-1:0] gap_cnt;
  state_t           state, state_next;

  assign raw = {RAW_SELECT, RAW_OK, RAW_START, RAW_COIN_10, RAW_COIN_5, RAW_COIN_1};

  // Stage 0/1: two-flop synchroniser, then debounce on the second flop
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      db_d    <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      db_d    <= db;
      for (int i = 0; i < 6; i++) begin
        if (sync_p1[i] != db[i]) begin
          if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db[i]  <= sync_p1[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = db & ~db_d;

`ifdef JAM_DETECT_EN
  localparam int JAM_W = $clog2(JAM_CYCLES + 1);
  logic [JAM_W-1:0] hold [3];

  // Hold counters measure how long each debounced coin line has stayed high
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      jam <= 1'b0;
      for (int k = 0; k < 3; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!db[k])                                  hold[k] <= '0;
        else if (hold[k] != JAM_W'(JAM_CYCLES))      hold[k] <= hold[k] + 1'b1;
        if (hold[k] == JAM_W'(JAM_CYCLES))           jam     <= 1'b1;
      end
    end
  end
`else
  assign jam = 1'b0;
`endif

  // Fixed priority 10 > 5 > 1 over non-empty queues
  always_comb begin
    pick = 3'b000;
    if (pend[2] != 2'd0)      pick = 3'b100;
    else if (pend[1] != 2'd0) pick = 3'b010;
    else if (pend[0] != 2'd0) pick = 3'b001;
  end

  assign acc  = rise[2:0] & {3{~jam}};
  assign deq  = (state == IDLE) ? pick : 3'b000;
  // A dequeue on the same queue frees the slot, so the coin is kept
  assign drop = acc & ~deq &
                {pend[2] == 2'(PEND_MAX), pend[1] == 2'(PEND_MAX), pend[0] == 2'(PEND_MAX)};

  always_ff @(posedge CLOCK) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick != 3'b000) state_next = EMIT;
      EMIT:    state_next = GAP;
      GAP:     if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage 2: queues, emit bookkeeping and registered pulses
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      sel     <= '0;
      gap_cnt <= '0;
      ovf     <= 1'b0;
      btn     <= '0;
      for (int k = 0; k < 3; k++) pend[k] <= '0;
    end else begin
      if (state == IDLE && pick != 3'b000) sel <= pick;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      ovf     <= |drop;
      btn     <= rise[5:3];
      for (int k = 0; k < 3; k++) begin
        if (acc[k] && !deq[k] && !drop[k]) pend[k] <= pend[k] + 1'b1;
        else if (deq[k] && !acc[k])        pend[k] <= pend[k] - 1'b1;
      end
    end
  end

  assign {COIN_10, COIN_5, COIN_1} = (state == EMIT) ? sel : 3'b000;
  assign {SELECT, OK, START}       = btn;
  assign COIN_OVF                  = ovf;
  assign JAM                       = jam;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner
//   Directed and random stimulus for coin_input_conditioner, compared every
//   cycle against a behavioural model built from sample-window debounce,
//   per-denomination coin counts and an emitter "free at cycle" timestamp.
//   A second instance with a long gap keeps the emitter busy so that queue
//   overflow can be exercised.
module tb_coin_input_conditioner;

  localparam int D    = 4;
  localparam int PM   = 3;
  localparam int GAPC = 1;
  localparam int JAMC = 64;

  logic       CLOCK = 1'b0;
  logic       nRESET = 1'b0;
  logic [5:0] raw = 6'b111111;

  logic coin_1, coin_5, coin_10, btn_start, btn_ok, btn_select, coin_ovf, jam;
  logic s_coin_1, s_coin_5, s_coin_10, s_start, s_ok, s_select, s_ovf, s_jam;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK = ~CLOCK;

  coin_input_conditioner dut (
    .CLOCK(CLOCK), .nRESET(nRESET),
    .RAW_COIN_1(raw[0]), .RAW_COIN_5(raw[1]), .RAW_COIN_10(raw[2]),
    .RAW_START(raw[3]), .RAW_OK(raw[4]), .RAW_SELECT(raw[5]),
    .COIN_1(coin_1), .COIN_5(coin_5), .COIN_10(coin_10),
    .START(btn_start), .OK(btn_ok), .SELECT(btn_select),
    .COIN_OVF(coin_ovf), .JAM(jam)
  );

  coin_input_conditioner #(.GAP_CYCLES(30)) dut_slow (
    .CLOCK(CLOCK), .nRESET(nRESET),
    .RAW_COIN_1(raw[0]), .RAW_COIN_5(raw[1]), .RAW_COIN_10(raw[2]),
    .RAW_START(raw[3]), .RAW_OK(raw[4]), .RAW_SELECT(raw[5]),
    .COIN_1(s_coin_1), .COIN_5(s_coin_5), .COIN_10(s_coin_10),
    .START(s_start), .OK(s_ok), .SELECT(s_select),
    .COIN_OVF(s_ovf), .JAM(s_jam)
  );

  // Reference model state
  int          cyc = 0;
  logic [15:0] hist [6];
  logic [5:0]  m_db = '0;
  logic [5:0]  m_rose = '0;
  int          m_pend [3];
  int          m_free = 0;
  int          m_hi_since [3];
  int          m_hi_prev [3];
  logic        m_jam = 1'b0;
  logic [2:0]  e_coin = '0;
  logic [2:0]  e_btn = '0;
  logic        e_ovf = 1'b0;
  logic        e_jam = 1'b0;

  always @(posedge CLOCK) begin : model
    logic [5:0]  rose_old, db_new;
    logic [15:0] mask, win;
    int          pend_old [3];
    int          deq;
    logic        jam_old, jam_hit, a;
    cyc++;
    if (!nRESET) begin
      for (int c = 0; c < 6; c++) hist[c] = '0;
      for (int k = 0; k < 3; k++) begin
        m_pend[k] = 0; m_hi_since[k] = -1; m_hi_prev[k] = -1;
      end
      m_db = '0; m_rose = '0; m_free = 0; m_jam = 1'b0;
      e_coin = '0; e_btn = '0; e_ovf = 1'b0; e_jam = 1'b0;
    end else begin
      rose_old = m_rose;
      jam_old  = m_jam;
      pend_old = m_pend;
      mask     = 16'((1 << D) - 1);
      // A level flips once the last D synchronised samples all disagree with it
      for (int c = 0; c < 6; c++) begin
        win       = (hist[c] >> 1) & mask;
        db_new[c] = m_db[c];
        if (!m_db[c] && win == mask)   db_new[c] = 1'b1;
        else if (m_db[c] && win == '0) db_new[c] = 1'b0;
        hist[c] = {hist[c][14:0], raw[c]};
      end
      jam_hit = 1'b0;
`ifdef JAM_DETECT_EN
      for (int k = 0; k < 3; k++) begin
        if (m_hi_prev[k] >= 0 && (cyc - 1) - m_hi_prev[k] >= JAMC) jam_hit = 1'b1;
        m_hi_prev[k]  = m_hi_since[k];
        m_hi_since[k] = db_new[k] ? (m_db[k] ? m_hi_since[k] : cyc) : -1;
      end
`endif
      m_rose = db_new & ~m_db;
      m_db   = db_new;
      m_jam  = jam_old | jam_hit;
      e_btn  = rose_old[5:3];
      deq    = -1;
      if (cyc >= m_free) begin
        for (int k = 2; k >= 0; k--) if (deq < 0 && pend_old[k] > 0) deq = k;
        if (deq >= 0) m_free = cyc + GAPC + 2;
      end
      e_coin = (deq >= 0) ? 3'(1 << deq) : 3'b000;
      e_ovf  = 1'b0;
      for (int k = 0; k < 3; k++) begin
        a = rose_old[k] && !jam_old;
        if (a && deq != k && pend_old[k] == PM) e_ovf = 1'b1;
        else m_pend[k] = pend_old[k] + int'(a) - int'(deq == k);
      end
      e_jam = m_jam;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  int slow_c1, slow_c5, slow_c10, slow_ovf, slow_btn;
  bit slow_count = 0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK);
      chk("COIN_1", coin_1, e_coin[0]);
      chk("COIN_5", coin_5, e_coin[1]);
      chk("COIN_10", coin_10, e_coin[2]);
      chk("START", btn_start, e_btn[0]);
      chk("OK", btn_ok, e_btn[1]);
      chk("SELECT", btn_select, e_btn[2]);
      chk("COIN_OVF", coin_ovf, e_ovf);
      chk("JAM", jam, e_jam);
      if (slow_count) begin
        slow_c1  += int'(s_coin_1);
        slow_c5  += int'(s_coin_5);
        slow_c10 += int'(s_coin_10);
        slow_ovf += int'(s_ovf);
        slow_btn += int'(s_start) + int'(s_ok) + int'(s_select);
      end
    end
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    step(1);
    nRESET = 1'b1;
  endtask

  initial begin
    int n, at, t10, t5, t1;

    // Reset with every raw line high, then release lines together with reset
    step(2);
    chk_int("t1_reset_outputs", int'({coin_1, coin_5, coin_10, btn_start, btn_ok,
                                       btn_select, coin_ovf, jam}), 0);
    raw = '0;
    nRESET = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      n += int'(coin_1) + int'(coin_5) + int'(coin_10) + int'(btn_start) +
           int'(btn_ok) + int'(btn_select) + int'(coin_ovf);
    end
    chk_int("t1_no_pulses_after_release", n, 0);

    // Short glitch on OK, then a real press
    n = 0;
    raw[4] = 1'b1;
    for (int i = 0; i < 2; i++) begin step(1); n += int'(btn_ok); end
    raw[4] = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); n += int'(btn_ok); end
    chk_int("t2_glitch_no_pulse", n, 0);
    n = 0; at = -1;
    raw[4] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step(1);
      if (btn_ok) begin n++; if (at < 0) at = i; end
      if (i == 10) raw[4] = 1'b0;
    end
    chk_int("t2_ok_latency", at, 7);
    chk_int("t2_ok_count", n, 1);

    // All three coins together: serialised 10, 5, 1
    t10 = -1; t5 = -1; t1 = -1;
    raw[2:0] = 3'b111;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (coin_10 && t10 < 0) t10 = i;
      if (coin_5 && t5 < 0)   t5 = i;
      if (coin_1 && t1 < 0)   t1 = i;
      if (i == 6) raw[2:0] = 3'b000;
    end
    chk_int("t3_coin10_at", t10, 8);
    chk_int("t3_coin5_at", t5, 11);
    chk_int("t3_coin1_at", t1, 14);

    // Overflow with the long-gap instance held busy by queued COIN_10
    do_reset();
    slow_c1 = 0; slow_c5 = 0; slow_c10 = 0; slow_ovf = 0; slow_btn = 0;
    slow_count = 1;
    for (int i = 0; i < 4; i++) begin raw[2] = 1'b1; step(5); raw[2] = 1'b0; step(5); end
    for (int i = 0; i < 5; i++) begin raw[1] = 1'b1; step(5); raw[1] = 1'b0; step(5); end
    step(140);
    slow_count = 0;
    chk_int("t4_coin10_pulses", slow_c10, 4);
    chk_int("t4_coin5_pulses", slow_c5, 3);
    chk_int("t4_coin1_pulses", slow_c1, 0);
    chk_int("t4_ovf_pulses", slow_ovf, 2);
    chk_int("t4_no_button_pulses", slow_btn, 0);
    chk("t4_no_jam", s_jam, 1'b0);

    // Reset while two coins are still queued
    do_reset();
    t10 = -1;
    raw[2:0] = 3'b111;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      if (coin_10 && t10 < 0) t10 = i;
      if (i == 6) raw[2:0] = 3'b000;
    end
    chk_int("t5_first_coin10", t10, 8);
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n += int'(coin_1) + int'(coin_5) + int'(coin_10);
    end
    chk_int("t5_queue_dropped", n, 0);
    t1 = -1;
    raw[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (coin_1 && t1 < 0) t1 = i;
      if (i == 6) raw[0] = 1'b0;
    end
    chk_int("t5_insert_after_reset", t1, 8);

    // Random lines with random hold times, glitches included
    for (int i = 0; i < 80; i++) begin
      raw = 6'($urandom);
      step($urandom_range(1, 8));
    end
    raw = '0;
    step(20);

    // Every coin line toggling at the fastest debounce rate outruns the emitter
    for (int i = 0; i < 30; i++) begin
      raw[2:0] = 3'b111; step(4);
      raw[2:0] = 3'b000; step(4);
    end
    step(40);

`ifdef JAM_DETECT_EN
    do_reset();
    n = 0;
    raw[0] = 1'b1;
    for (int i = 0; i < 80; i++) begin step(1); n += int'(coin_1); end
    raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); n += int'(coin_1); end
    chk_int("t6_single_coin1", n, 1);
    chk("t6_jam_set", jam, 1'b1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      raw[2] = 1'b1;
      for (int j = 0; j < 5; j++) begin step(1); n += int'(coin_10) + int'(coin_ovf); end
      raw[2] = 1'b0;
      for (int j = 0; j < 5; j++) begin step(1); n += int'(coin_10) + int'(coin_ovf); end
    end
    step(10);
    chk_int("t6_coin10_ignored", n, 0);
    chk("t6_jam_sticky", jam, 1'b1);
    do_reset();
    step(1);
    chk("t6_jam_cleared", jam, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
